// File: rtl/uart_defs.sv
// Shared UART transmitter definitions: FSM state encodings,
// serial line levels and the default bit period.
package uart_defs;

    // 3-bit state encodings for the transmit FSM
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_t;

    // Serial line levels
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Ports: clk, reset (async, active-high), clear (sync count clear),
//        enable (count advance), bit_tick (1-cycle end-of-bit pulse).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = uart_defs::DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Tick is combinational so the FSM sees it in the last cycle
    // of the bit and moves on at the closing edge.
    assign bit_tick = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining the TX FIFO: pops a byte when idle and
// sends start, 8 data bits LSB first, optional parity, 1-2 stops.
// Ports: clk, reset (async, active-high), fifo_empty, fifo_rd_en,
//        fifo_rd_data, uart_txd, tx_busy, tx_done.
module uart_tx_fifo_reader
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_rd_data,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2))
    begin : g_bad_params
        $error("uart_tx_fifo_reader: illegal CLKS_PER_BIT/STOP_BITS");
    end

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    tx_state_t  state;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       parity_bit;
    logic       bit_tick;
    logic       baud_clear;
    logic       baud_en;

    assign baud_clear = (state == S_FETCH);
    assign baud_en    = (state != S_IDLE) && (state != S_FETCH);

    // Pop only from IDLE; the FSM leaves IDLE on the same edge,
    // so exactly one strobe per byte.
    assign fifo_rd_en = (state == S_IDLE) && !fifo_empty && !reset;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .enable  (baud_en),
        .bit_tick(bit_tick)
    );

    // uart_txd is loaded with the level of the state being entered,
    // so the line changes on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            uart_txd   <= LINE_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= S_FETCH;
                        tx_busy <= 1'b1;
                    end
                end
                S_FETCH: begin
                    shift_reg  <= fifo_rd_data;
                    parity_bit <= (^fifo_rd_data) ^ ODD;
                    bit_idx    <= '0;
                    uart_txd   <= LINE_START;
                    state      <= S_START;
                end
                S_START: begin
                    if (bit_tick) begin
                        uart_txd <= shift_reg[0];
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                uart_txd <= parity_bit;
                                state    <= S_PARITY;
                            end else begin
                                uart_txd <= LINE_STOP;
                                state    <= S_STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            uart_txd  <= shift_reg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        uart_txd <= LINE_STOP;
                        bit_idx  <= '0;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    uart_txd <= LINE_IDLE;
                    tx_busy  <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed testbench for uart_tx_fifo_reader: four instances
// (plain, even parity, odd parity, two stop bits) with FIFO models.
module tb_uart_tx_fifo_reader;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] empty;
    logic [3:0] rd_en;
    logic [3:0] txd;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] rd_data [4];

    logic [7:0] mem [4][16];
    int wr_ptr [4] = '{0, 0, 0, 0};
    int rd_ptr [4] = '{0, 0, 0, 0};
    int pops   [4] = '{0, 0, 0, 0};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0: plain, 1: even parity, 2: odd parity, 3: two stops
    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(CPB), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .reset(reset), .fifo_empty(empty[0]),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]),
        .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(CPB), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(empty[1]),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]),
        .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(CPB), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(1)
    ) dut2 (
        .clk(clk), .reset(reset), .fifo_empty(empty[2]),
        .fifo_rd_en(rd_en[2]), .fifo_rd_data(rd_data[2]),
        .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(CPB), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(2)
    ) dut3 (
        .clk(clk), .reset(reset), .fifo_empty(empty[3]),
        .fifo_rd_en(rd_en[3]), .fifo_rd_data(rd_data[3]),
        .uart_txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3])
    );

    // FIFO models: registered read data one cycle after the pop
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i]) begin
                rd_data[i] <= mem[i][rd_ptr[i] % 16];
                rd_ptr[i]  <= rd_ptr[i] + 1;
                pops[i]    <= pops[i] + 1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int i = 0; i < 4; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr_ptr[i] % 16] = b;
        wr_ptr[i] = wr_ptr[i] + 1;
        #1;
    endtask

    // Leaves the caller at the negedge of the pop cycle T
    task automatic wait_pop(input int i, output int waits);
        waits = 0;
        while (!rd_en[i] && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!rd_en[i]) begin
            chk($sformatf("pop_timeout[%0d]", i), 0, 1);
        end
    endtask

    // Checks one frame cycle by cycle from the pop to tx_done
    task automatic check_frame(input int i,
                               input logic [7:0] b,
                               input int par_en,
                               input logic par_bit,
                               input int stops,
                               output int waits);
        logic [11:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = b[k];
        if (par_en != 0) bits[9] = par_bit;
        nb = 9 + par_en + stops;
        wait_pop(i, waits);
        if (!rd_en[i]) return;
        @(negedge clk);
        chk($sformatf("fetch_rd_en[%0d]", i), rd_en[i], 0);
        chk($sformatf("fetch_busy[%0d]", i), busy[i], 1);
        chk($sformatf("fetch_txd[%0d]", i), txd[i], 1);
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk($sformatf("txd[%0d] bit%0d cyc%0d", i, k, c),
                    txd[i], bits[k]);
                chk($sformatf("busy[%0d] bit%0d", i, k),
                    busy[i], 1);
                chk($sformatf("done_early[%0d] bit%0d", i, k),
                    done[i], 0);
                chk($sformatf("rd_en_busy[%0d] bit%0d", i, k),
                    rd_en[i], 0);
            end
        end
        @(negedge clk);
        chk($sformatf("done[%0d]", i), done[i], 1);
        chk($sformatf("idle_busy[%0d]", i), busy[i], 0);
        chk($sformatf("idle_txd[%0d]", i), txd[i], 1);
    endtask

    initial begin
        int w;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", {28'd0, txd}, 32'hF);
        chk("rst_busy", {28'd0, busy}, 0);
        chk("rst_done", {28'd0, done}, 0);
        chk("rst_rd_en", {28'd0, rd_en}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Empty FIFO: nothing moves for 100 cycles
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("idle_outs", {rd_en[0], txd[0], busy[0], done[0]},
                4'b0100);
        end
        chk("idle_pops", pops[0], 0);

        // 0x55 single frame
        push(0, 8'h55);
        check_frame(0, 8'h55, 0, 1'b0, 1, w);
        @(negedge clk);
        chk("done_pulse_end", done[0], 0);
        chk("pops_55", pops[0], 1);

        // Back-to-back 0xA3, 0x0F: second pop in the tx_done cycle
        push(0, 8'hA3);
        push(0, 8'h0F);
        check_frame(0, 8'hA3, 0, 1'b0, 1, w);
        check_frame(0, 8'h0F, 0, 1'b0, 1, w);
        chk("b2b_no_gap_wait", w, 0);
        chk("pops_b2b", pops[0], 3);

        // Parity: 0x07 -> even 1, odd 0
        push(1, 8'h07);
        check_frame(1, 8'h07, 1, 1'b1, 1, w);
        push(2, 8'h07);
        check_frame(2, 8'h07, 1, 1'b0, 1, w);

        // Two stop bits, 0xFF
        push(3, 8'hFF);
        check_frame(3, 8'hFF, 0, 1'b0, 2, w);

        // Reset in the middle of data bit 0 of 0x00
        @(negedge clk);
        push(0, 8'h00);
        push(0, 8'h3C);
        wait_pop(0, w);
        repeat (8) @(negedge clk);
        chk("pre_rst_txd", txd[0], 0);
        chk("pre_rst_busy", busy[0], 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_txd", txd[0], 1);
        chk("async_rst_busy", busy[0], 0);
        chk("async_rst_done", done[0], 0);
        chk("async_rst_rd_en", rd_en[0], 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_rd_en", rd_en[0], 0);
            chk("rst_hold_txd", txd[0], 1);
        end
        chk("pops_discard", pops[0], 4);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_frame(0, 8'h3C, 0, 1'b0, 1, w);
        chk("post_rst_wait", w, 0);
        chk("pops_final", pops[0], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
Byte-serial UART transmitter that drains the 8-bit TX FIFO written by the AXI-Lite slave. It pops one byte whenever the FIFO is non-empty and the transmitter is idle. It serialises the byte as start, 8 data bits (LSB first), optional parity, and 1 or 2 stop bits on uart_txd. It is the last stage of the AXI -> FIFO -> UART path.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit period (50 MHz / 115200); legal range >= 2
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO has no data
fifo_rd_en  output  1  pop strobe; FIFO presents data on fifo_rd_data the cycle after the strobe
fifo_rd_data  input  8  FIFO read data, registered, valid the cycle after fifo_rd_en
uart_txd  output  1  serial line, idles high
tx_busy  output  1  high whenever the state is not IDLE
tx_done  output  1  one-cycle pulse when the final stop-bit period ends

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - uart_txd=1, tx_busy=0, tx_done=0.
  - fifo_rd_en=0 for as long as reset is asserted.
  - Baud counter, bit index and shift register are cleared.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_rd_en = !fifo_empty (combinational, gated by !reset).
  - If !fifo_empty, next state is FETCH. fifo_rd_en is high for exactly one cycle per byte.
- FETCH (1 cycle):
  - Latch fifo_rd_data into the shift register.
  - Compute the parity bit: XOR of the data, inverted when PARITY_ODD=1.
  - Clear the baud counter; next state is START.
- uart_txd is a registered output. It takes the bit value of the state being entered on the same edge, so the line falls low at the edge ending FETCH.
- Bit timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1. A bit period ends when the counter reaches CLKS_PER_BIT-1; the counter then resets to 0.
  - Counter width is $clog2(CLKS_PER_BIT).
- Transitions:
  - START -> DATA.
  - DATA shifts LSB first. The bit index runs 0..7; after bit 7 go to PARITY if PARITY_EN, else STOP.
  - PARITY -> STOP.
  - STOP lasts STOP_BITS bit periods, then IDLE with tx_done=1 for that single cycle.
- Frame length, start of START to end of STOP: CLKS_PER_BIT*(9+PARITY_EN+STOP_BITS) cycles.
- Latency:
  - The rd_en cycle is T; FETCH is T+1.
  - The start bit is visible on uart_txd from cycle T+2.
- Back-to-back frames: after STOP, the IDLE and FETCH cycles keep the line high. The effective stop level therefore lasts STOP_BITS*CLKS_PER_BIT+2 cycles before the next start bit. No prefetch.
- fifo_empty changing during a frame has no effect. The data byte is held in the internal shift register.
- Reset mid-frame: uart_txd returns to 1 immediately (asynchronously). The popped byte is discarded and no tx_done is issued.
- fifo_rd_en is never asserted outside IDLE, so the block cannot pop while busy.
- Illegal parameters (CLKS_PER_BIT<2, STOP_BITS not in {1,2}) are flagged by an elaboration-time check.

Decomposition:
- Shared include/package uart_defs: state encodings (3-bit localparams), line idle/start/stop levels, default CLKS_PER_BIT.
- One sub-module: uart_baud_gen, with the following behaviour:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, reset, clear, enable.
  - Output bit_tick, a 1-cycle pulse when the count reaches CLKS_PER_BIT-1.
- The FSM, shift register and bit index stay in the top module.

Test Plan:
- CLKS_PER_BIT=4, no parity, STOP_BITS=1. FIFO holds 0x55 -> fifo_rd_en high 1 cycle; uart_txd from T+2 is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_done pulses once at cycle T+2+40; tx_busy high T+1..T+41.
- PARITY_EN=1, even. Byte 0x07 -> parity bit 1; frame is 11 bits (44 cycles). With PARITY_ODD=1 the parity bit is 0.
- Two bytes 0xA3 then 0x0F queued back-to-back -> exactly two rd_en pulses. Line is high for 4+2 cycles between the frames. Decoded bits match LSB-first 0xA3 then 0x0F.
- fifo_empty held high for 100 cycles -> fifo_rd_en never asserted; uart_txd=1, tx_busy=0, tx_done=0 throughout.
- Reset asserted mid-DATA of 0x00 (line low) -> uart_txd=1 asynchronously, all outputs at reset values. After release with FIFO non-empty, the next byte starts cleanly with a full start bit.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0xFF -> line low only for the 4-cycle start bit; tx_done pulses 44 cycles after the start-bit edge.
